// File: rtl/stream_mux_n_to_1_if.sv
// stream_mux_n_to_1_if: N-channel input streams plus one merged output stream
interface stream_mux_n_to_1_if #(
  parameter int N = 8,
  parameter int W = 8
);
  localparam int SW = $clog2(N);
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_last;
  logic [N-1:0]   in_ready;
  logic [SW-1:0]  sel;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic [SW-1:0]  out_ch;
  logic           out_valid;
  logic           out_ready;
  modport slave (
    input  in_data, in_valid, in_last, sel, out_ready,
    output in_ready, out_data, out_last, out_ch, out_valid
  );
  modport master (
    output in_data, in_valid, in_last, sel, out_ready,
    input  in_ready, out_data, out_last, out_ch, out_valid
  );
endinterface

// File: rtl/stream_mux_n_to_1.sv
// stream_mux_n_to_1: registered N:1 packet stream mux, locked per packet, sel or round-robin choice
module stream_mux_n_to_1 #(
  parameter int N    = 8,
  parameter int W    = 8,
  parameter int MODE = 0
) (
  input logic                 clk,
  input logic                 rst,
  stream_mux_n_to_1_if.slave  bus
);
  localparam int SW = $clog2(N);
  localparam logic [N-1:0] ONE = 1;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t        r_state, w_state_nxt;
  logic [SW-1:0] r_lock, r_rr, r_ch, w_cur, w_rr_ch;
  logic [W-1:0]  r_data;
  logic          r_last, r_valid;
  logic          w_rr_hit, w_chosen, w_grant, w_acc, w_cur_last;
  // first valid channel after the last packet winner; descending scan so the nearest one wins
  always_comb begin
    w_rr_hit = 1'b0;
    w_rr_ch = '0;
    for (int j = N; j >= 1; j--)
      if (bus.in_valid[(int'(r_rr) + j) % N]) begin
        w_rr_hit = 1'b1;
        w_rr_ch = SW'((int'(r_rr) + j) % N);
      end
  end
  // channel choice, grant and accept; an open packet keeps the lock on its channel
  always_comb begin
    w_cur = r_state == BUSY ? r_lock : MODE == 0 ? bus.sel : w_rr_ch;
    w_chosen = !rst && (r_state == BUSY || (MODE == 0 ? int'(bus.sel) < N : w_rr_hit));
    w_grant = w_chosen && (!r_valid || bus.out_ready);
    w_acc = w_grant && bus.in_valid[w_cur];
    w_cur_last = bus.in_last[w_cur];
    bus.in_ready = w_grant ? ONE << w_cur : '0;
  end
  // packet lock: a non-last beat opens a packet, a last beat closes it
  always_comb begin
    w_state_nxt = w_acc ? (w_cur_last ? IDLE : BUSY) : r_state;
  end
  // state, lock channel and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_lock <= '0;
      r_rr <= SW'(N - 1);
    end else begin
      r_state <= w_state_nxt;
      if (w_acc && !w_cur_last) r_lock <= w_cur;
      if (w_acc && w_cur_last) r_rr <= w_cur;
    end
  end
  // single-entry output register; load overwrites a beat being drained, so no bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data <= '0;
      r_last <= 1'b0;
      r_ch <= '0;
    end else if (w_acc) begin
      r_valid <= 1'b1;
      r_data <= bus.in_data[w_cur*W +: W];
      r_last <= w_cur_last;
      r_ch <= w_cur;
    end else if (bus.out_ready) begin
      r_valid <= 1'b0;
    end
  end
  assign bus.out_data = r_data;
  assign bus.out_last = r_last;
  assign bus.out_ch = r_ch;
  assign bus.out_valid = r_valid;
endmodule

// File: tb/tb_stream_mux_n_to_1.sv
// tb_stream_mux_n_to_1: directed + random checks of three mux configurations against a behavioural model
module tb_stream_mux_n_to_1;
  logic clk, rst, ord;
  logic [7:0] d [8];
  logic [7:0] v, l;
  logic [2:0] sel;
  logic [63:0] dp;
  int total = 0, bad = 0;
  stream_mux_n_to_1_if #(.N(8), .W(8)) ifa ();
  stream_mux_n_to_1_if #(.N(8), .W(8)) ifb ();
  stream_mux_n_to_1_if #(.N(6), .W(8)) ifc ();
  stream_mux_n_to_1 #(.N(8), .W(8), .MODE(0)) u_a (.clk(clk), .rst(rst), .bus(ifa));
  stream_mux_n_to_1 #(.N(8), .W(8), .MODE(1)) u_b (.clk(clk), .rst(rst), .bus(ifb));
  stream_mux_n_to_1 #(.N(6), .W(8), .MODE(0)) u_c (.clk(clk), .rst(rst), .bus(ifc));
  always_comb for (int i = 0; i < 8; i++) dp[i*8 +: 8] = d[i];
  assign ifa.in_data = dp;
  assign ifb.in_data = dp;
  assign ifc.in_data = dp[47:0];
  assign ifa.in_valid = v;
  assign ifb.in_valid = v;
  assign ifc.in_valid = v[5:0];
  assign ifa.in_last = l;
  assign ifb.in_last = l;
  assign ifc.in_last = l[5:0];
  assign ifa.sel = sel;
  assign ifb.sel = sel;
  assign ifc.sel = sel;
  assign ifa.out_ready = ord;
  assign ifb.out_ready = ord;
  assign ifc.out_ready = ord;
  logic [7:0] o_rdy [3], o_d [3];
  logic       o_v [3], o_l [3];
  logic [2:0] o_c [3];
  always_comb begin
    o_rdy[0] = ifa.in_ready;
    o_rdy[1] = ifb.in_ready;
    o_rdy[2] = {2'b00, ifc.in_ready};
    o_d[0] = ifa.out_data;
    o_d[1] = ifb.out_data;
    o_d[2] = ifc.out_data;
    o_v[0] = ifa.out_valid;
    o_v[1] = ifb.out_valid;
    o_v[2] = ifc.out_valid;
    o_l[0] = ifa.out_last;
    o_l[1] = ifb.out_last;
    o_l[2] = ifc.out_last;
    o_c[0] = ifa.out_ch;
    o_c[1] = ifb.out_ch;
    o_c[2] = ifc.out_ch;
  end
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  // behavioural model state per instance
  int kn [3] = '{8, 8, 6};
  int km [3] = '{0, 1, 0};
  bit mv [3], ml [3], mb [3], op [3];
  logic [7:0] md [3];
  int mc [3], mk [3], mr [3], opc [3];
  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask
  task automatic mreset(input int k);
    mv[k] = 0; md[k] = 0; ml[k] = 0; mc[k] = 0; mb[k] = 0; mr[k] = kn[k] - 1; op[k] = 0;
  endtask
  task automatic model_eval(input int k, output logic [7:0] rdy, output int cur, output bit acc);
    bit chosen;
    chosen = 0;
    cur = 0;
    if (!rst) begin
      if (mb[k]) begin
        cur = mk[k];
        chosen = 1;
      end else if (km[k] == 0) begin
        cur = int'(sel);
        chosen = cur < kn[k];
      end else begin
        for (int j = 1; j <= kn[k] && !chosen; j++) begin
          int c;
          c = (mr[k] + j) % kn[k];
          if (v[c]) begin
            cur = c;
            chosen = 1;
          end
        end
      end
    end
    rdy = (chosen && (!mv[k] || ord)) ? 8'(1 << cur) : 8'h00;
    acc = rdy[cur] && v[cur];
  endtask
  task automatic step();
    logic [7:0] rdy;
    int cur;
    bit acc;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      model_eval(k, rdy, cur, acc);
      chk("in_ready", k, 32'(o_rdy[k]), 32'(rdy));
      chk("out_valid", k, 32'(o_v[k]), 32'(mv[k]));
      chk("out_data", k, 32'(o_d[k]), 32'(md[k]));
      chk("out_last", k, 32'(o_l[k]), 32'(ml[k]));
      chk("out_ch", k, 32'(o_c[k]), 32'(mc[k]));
      if (!rst && o_v[k] && ord) begin
        if (op[k]) chk("no_interleave", k, 32'(o_c[k]), 32'(opc[k]));
        op[k] = !o_l[k];
        opc[k] = int'(o_c[k]);
      end
      if (rst) mreset(k);
      else if (acc) begin
        mv[k] = 1; md[k] = d[cur]; ml[k] = l[cur]; mc[k] = cur;
        if (l[cur]) begin
          mb[k] = 0;
          mr[k] = cur;
        end else begin
          mb[k] = 1;
          mk[k] = cur;
        end
      end else if (ord) mv[k] = 0;
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [7:0] hd;
    logic [2:0] hc;
    rst = 1'b1; ord = 1'b1; v = 0; l = 0; sel = 0;
    for (int i = 0; i < 8; i++) d[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) mreset(k);
    for (int k = 0; k < 3; k++) begin
      chk("rst_valid", k, 32'(o_v[k]), 0);
      chk("rst_data", k, 32'(o_d[k]), 0);
      chk("rst_ch", k, 32'(o_c[k]), 0);
      chk("rst_rdy", k, 32'(o_rdy[k]), 0);
    end
    rst = 1'b0;
    step();
    // single-beat packet on ch3 via sel
    sel = 3; v = 8'h08; l = 8'hFF; d[3] = 8'hA5;
    #1;
    chk("t1_rdy", 0, 32'(o_rdy[0]), 32'h08);
    step();
    v = 0;
    chk("t1_valid", 0, 32'(o_v[0]), 1);
    chk("t1_data", 0, 32'(o_d[0]), 32'hA5);
    chk("t1_ch", 0, 32'(o_c[0]), 3);
    chk("t1_last", 0, 32'(o_l[0]), 1);
    step();
    // 3-beat packet on ch2; sel moves to 5 mid-packet
    sel = 2; v = 8'h04; l = 8'h00; d[2] = 8'h11;
    step();
    chk("t2_b1", 0, 32'(o_d[0]), 32'h11);
    sel = 5; v = 8'h24; l = 8'h20; d[2] = 8'h22; d[5] = 8'h55;
    step();
    chk("t2_b2", 0, 32'(o_d[0]), 32'h22);
    chk("t2_b2_ch", 0, 32'(o_c[0]), 2);
    d[2] = 8'h33; l = 8'h24;
    step();
    chk("t2_b3", 0, 32'(o_d[0]), 32'h33);
    chk("t2_b3_ch", 0, 32'(o_c[0]), 2);
    step();
    chk("t2_ch5", 0, 32'(o_c[0]), 5);
    chk("t2_d5", 0, 32'(o_d[0]), 32'h55);
    // round-robin over all channels, single-beat packets, no bubbles
    v = 0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) d[i] = 8'h30 + 8'(i);
    v = 8'hFF; l = 8'hFF; sel = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      chk("t3_valid", 1, 32'(o_v[1]), 1);
      chk("t3_ch", 1, 32'(o_c[1]), i % 8);
    end
    // backpressure holds the output and blocks every input
    ord = 0;
    hd = o_d[1];
    hc = o_c[1];
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t4_rdy", 1, 32'(o_rdy[1]), 0);
      step();
      chk("t4_data", 1, 32'(o_d[1]), 32'(hd));
      chk("t4_ch", 1, 32'(o_c[1]), 32'(hc));
    end
    ord = 1;
    step();
    chk("t4_next_ch", 1, 32'(o_c[1]), 32'((hc + 3'd1)));
    step();
    // reset mid-packet on ch1, then ch0 is granted first
    v = 0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    sel = 1; v = 8'h02; l = 8'h00;
    for (int i = 0; i < 2; i++) begin
      d[1] = 8'h40 + 8'(i);
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) chk("t5_valid", k, 32'(o_v[k]), 0);
    v = 8'h03; l = 8'h03; d[0] = 8'hC0; d[1] = 8'hC1;
    #1;
    chk("t5_rdy", 1, 32'(o_rdy[1]), 32'h01);
    step();
    chk("t5_ch", 1, 32'(o_c[1]), 0);
    chk("t5_data", 1, 32'(o_d[1]), 32'hC0);
    // out-of-range sel on the 6-channel instance selects nothing
    sel = 7; v = 8'hFF; l = 8'hFF;
    step();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t6_rdy", 2, 32'(o_rdy[2]), 0);
      step();
      chk("t6_valid", 2, 32'(o_v[2]), 0);
    end
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 8; i++) d[i] = 8'($urandom);
      v = 8'($urandom);
      l = 8'($urandom) & 8'($urandom);
      sel = 3'($urandom);
      ord = $urandom_range(0, 3) != 0;
      rst = $urandom_range(0, 199) == 0;
      step();
    end
    rst = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
